// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath core: widths, data types and the
// opcode encodings (instruction[15:12]) understood by the ALU.
package datapath_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [3:0]        opcode_t;

    localparam opcode_t OP_LDI = 4'b0001;
    localparam opcode_t OP_ADD = 4'b0010;
    localparam opcode_t OP_SUB = 4'b0011;
    localparam opcode_t OP_AND = 4'b0100;
    localparam opcode_t OP_OR  = 4'b0101;
    localparam opcode_t OP_XOR = 4'b0110;
    localparam opcode_t OP_NOT = 4'b0111;
    localparam opcode_t OP_JMP = 4'b1000;
    localparam opcode_t OP_SHL = 4'b1001;
    localparam opcode_t OP_SHR = 4'b1010;
    localparam opcode_t OP_BR  = 4'b1100;
    localparam opcode_t OP_OUT = 4'b1111;

endpackage

// File: rtl/datapath_core_gpr_bank.sv
// General-purpose register bank: 2**ADDR_W registers of DATA_W bits.
// Ports:
//   clk, rst          - rising-edge clock, async active-high clear
//   we_i, waddr_i,
//   wdata_i           - synchronous write port
//   raddr_a_i/_b_i    - read addresses
//   rdata_a_o/_b_o    - combinational read data (no write bypass)
module gpr_bank
    import datapath_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_a_o,
    output logic [DW-1:0] rdata_b_o
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0] regs_q [NREG];

    // Reset has priority, so a write attempted while rst is high is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/datapath_core.sv
// Register file plus ALU execution core.
// Ports:
//   clk, rst                  - clock and async active-high reset (registers only)
//   opcode                    - ALU operation select
//   address_a / address_b     - read addresses; address_a is also the write target
//   write_enable, write_data  - synchronous write into register[address_a]
//   data_a / data_b           - combinational register reads
//   alu_result, alu_zero,
//   alu_carry                 - combinational ALU outputs
module datapath_core
    import datapath_pkg::*;
#(
    parameter int DATA_W = datapath_pkg::DATA_W,
    parameter int ADDR_W = datapath_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_zero,
    output logic              alu_carry
);

    gpr_bank #(
        .DW (DATA_W),
        .AW (ADDR_W)
    ) u_gpr_bank (
        .clk       (clk),
        .rst       (rst),
        .we_i      (write_enable),
        .waddr_i   (address_a),
        .wdata_i   (write_data),
        .raddr_a_i (address_a),
        .raddr_b_i (address_b),
        .rdata_a_o (data_a),
        .rdata_b_o (data_b)
    );

    // One extra bit captures the add carry; for subtraction the top bit of
    // the wrapped difference is the borrow (set exactly when a < b).
    logic [DATA_W:0] sum_w;
    logic [DATA_W:0] diff_w;

    assign sum_w  = {1'b0, data_a} + {1'b0, data_b};
    assign diff_w = {1'b0, data_a} - {1'b0, data_b};

    always_comb begin
        alu_result = data_a;
        alu_carry  = 1'b0;
        unique case (opcode)
            OP_ADD: begin
                alu_result = sum_w[DATA_W-1:0];
                alu_carry  = sum_w[DATA_W];
            end
            OP_SUB: begin
                alu_result = diff_w[DATA_W-1:0];
                alu_carry  = diff_w[DATA_W];
            end
            OP_AND: alu_result = data_a & data_b;
            OP_OR:  alu_result = data_a | data_b;
            OP_XOR: alu_result = data_a ^ data_b;
            OP_NOT: alu_result = ~data_a;
            OP_SHL: begin
                alu_result = {data_a[DATA_W-2:0], 1'b0};
                alu_carry  = data_a[DATA_W-1];
            end
            OP_SHR: begin
                alu_result = {1'b0, data_a[DATA_W-1:1]};
                alu_carry  = data_a[0];
            end
            default: begin
                alu_result = data_a;
                alu_carry  = 1'b0;
            end
        endcase
    end

    assign alu_zero = (alu_result == '0);

endmodule

// File: tb/tb_datapath_core.sv
module tb_datapath_core;

    logic        clk;
    logic        rst;
    logic [3:0]  opcode;
    logic [2:0]  address_a;
    logic [2:0]  address_b;
    logic        write_enable;
    logic [15:0] write_data;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        alu_carry;

    int checks = 0;
    int errors = 0;

    datapath_core dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .address_a    (address_a),
        .address_b    (address_b),
        .write_enable (write_enable),
        .write_data   (write_data),
        .data_a       (data_a),
        .data_b       (data_b),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [2:0] addr, input logic [15:0] val);
        @(negedge clk);
        address_a    = addr;
        write_data   = val;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    task automatic set_ops(input logic [2:0] aa, input logic [2:0] ab, input logic [3:0] op);
        @(negedge clk);
        address_a = aa;
        address_b = ab;
        opcode    = op;
        #1;
    endtask

    task automatic test_reset;
        // Initial reset: every register reads zero on both ports.
        for (int i = 0; i < 8; i++) begin
            address_a = 3'(i);
            address_b = 3'(7 - i);
            #1;
            checks++;
            if (data_a !== 16'h0000 || data_b !== 16'h0000) begin
                errors++;
                $display("FAIL reset_init r%0d: data_a=%h data_b=%h required 0000", i, data_a, data_b);
            end
        end
        // Writes while reset is held are dropped.
        address_a    = 3'd2;
        write_data   = 16'hBEEF;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        checks++;
        if (data_a !== 16'h0000) begin
            errors++;
            $display("FAIL reset_write_ignored: data_a=%h required 0000", data_a);
        end
        @(negedge clk);
        rst = 1'b0;
        // First edge after release accepts a write.
        do_write(3'd3, 16'h1234);
        address_a = 3'd3;
        #1;
        checks++;
        if (data_a !== 16'h1234) begin
            errors++;
            $display("FAIL write_r3: data_a=%h required 1234", data_a);
        end
        // Mid-cycle reset clears immediately, without a clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (data_a !== 16'h0000) begin
            errors++;
            $display("FAIL reset_async: data_a=%h required 0000", data_a);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            address_a = 3'(i);
            address_b = 3'(i);
            #1;
            checks++;
            if (data_a !== 16'h0000 || data_b !== 16'h0000) begin
                errors++;
                $display("FAIL reset_release r%0d: data_a=%h data_b=%h required 0000", i, data_a, data_b);
            end
        end
    endtask

    task automatic test_write_read_add;
        do_write(3'd1, 16'h0005);
        do_write(3'd2, 16'h0003);
        set_ops(3'd1, 3'd2, 4'b0010);
        checks++;
        if (data_a !== 16'h0005 || data_b !== 16'h0003) begin
            errors++;
            $display("FAIL read_ports: data_a=%h data_b=%h required 0005 0003", data_a, data_b);
        end
        checks++;
        if (alu_result !== 16'h0008 || alu_zero !== 1'b0 || alu_carry !== 1'b0) begin
            errors++;
            $display("FAIL add_basic: res=%h z=%b c=%b required 0008 0 0", alu_result, alu_zero, alu_carry);
        end
        set_ops(3'd2, 3'd2, 4'b0010);
        checks++;
        if (data_a !== 16'h0003 || data_b !== 16'h0003 || alu_result !== 16'h0006) begin
            errors++;
            $display("FAIL same_addr: a=%h b=%h res=%h required 0003 0003 0006", data_a, data_b, alu_result);
        end
        set_ops(3'd1, 3'd2, 4'b0101);
        checks++;
        if (alu_result !== 16'h0007 || alu_carry !== 1'b0) begin
            errors++;
            $display("FAIL or_basic: res=%h c=%b required 0007 0", alu_result, alu_carry);
        end
    endtask

    task automatic test_sub_zero;
        do_write(3'd1, 16'h0007);
        do_write(3'd2, 16'h0007);
        set_ops(3'd1, 3'd2, 4'b0011);
        checks++;
        if (alu_result !== 16'h0000 || alu_zero !== 1'b1 || alu_carry !== 1'b0) begin
            errors++;
            $display("FAIL sub_equal: res=%h z=%b c=%b required 0000 1 0", alu_result, alu_zero, alu_carry);
        end
        do_write(3'd1, 16'h0000);
        do_write(3'd2, 16'h0001);
        set_ops(3'd1, 3'd2, 4'b0011);
        checks++;
        if (alu_result !== 16'hFFFF || alu_zero !== 1'b0 || alu_carry !== 1'b1) begin
            errors++;
            $display("FAIL sub_borrow: res=%h z=%b c=%b required ffff 0 1", alu_result, alu_zero, alu_carry);
        end
        set_ops(3'd2, 3'd1, 4'b0011);
        checks++;
        if (alu_result !== 16'h0001 || alu_carry !== 1'b0) begin
            errors++;
            $display("FAIL sub_noborrow: res=%h c=%b required 0001 0", alu_result, alu_carry);
        end
    endtask

    task automatic test_read_during_write;
        do_write(3'd4, 16'h00AA);
        @(negedge clk);
        address_a    = 3'd4;
        write_data   = 16'h0055;
        write_enable = 1'b1;
        #1;
        checks++;
        if (data_a !== 16'h00AA) begin
            errors++;
            $display("FAIL rdw_before_edge: data_a=%h required 00aa", data_a);
        end
        @(posedge clk);
        #1;
        checks++;
        if (data_a !== 16'h0055) begin
            errors++;
            $display("FAIL rdw_after_edge: data_a=%h required 0055", data_a);
        end
        write_enable = 1'b0;
        write_data   = 16'h0099;
        @(posedge clk);
        #1;
        checks++;
        if (data_a !== 16'h0055) begin
            errors++;
            $display("FAIL rdw_we_low: data_a=%h required 0055", data_a);
        end
    endtask

    task automatic test_overflow_logic;
        do_write(3'd5, 16'hFFFF);
        do_write(3'd6, 16'h0001);
        set_ops(3'd5, 3'd6, 4'b0010);
        checks++;
        if (alu_result !== 16'h0000 || alu_zero !== 1'b1 || alu_carry !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap: res=%h z=%b c=%b required 0000 1 1", alu_result, alu_zero, alu_carry);
        end
        set_ops(3'd5, 3'd6, 4'b0100);
        checks++;
        if (alu_result !== 16'h0001 || alu_carry !== 1'b0 || alu_zero !== 1'b0) begin
            errors++;
            $display("FAIL and: res=%h z=%b c=%b required 0001 0 0", alu_result, alu_zero, alu_carry);
        end
        set_ops(3'd5, 3'd6, 4'b0110);
        checks++;
        if (alu_result !== 16'hFFFE || alu_carry !== 1'b0) begin
            errors++;
            $display("FAIL xor: res=%h c=%b required fffe 0", alu_result, alu_carry);
        end
        set_ops(3'd5, 3'd6, 4'b0111);
        checks++;
        if (alu_result !== 16'h0000 || alu_zero !== 1'b1 || alu_carry !== 1'b0) begin
            errors++;
            $display("FAIL not: res=%h z=%b c=%b required 0000 1 0", alu_result, alu_zero, alu_carry);
        end
    endtask

    task automatic test_shifts;
        do_write(3'd7, 16'h8001);
        set_ops(3'd7, 3'd0, 4'b1001);
        checks++;
        if (alu_result !== 16'h0002 || alu_carry !== 1'b1) begin
            errors++;
            $display("FAIL shl: res=%h c=%b required 0002 1", alu_result, alu_carry);
        end
        set_ops(3'd7, 3'd0, 4'b1010);
        checks++;
        if (alu_result !== 16'h4000 || alu_carry !== 1'b1) begin
            errors++;
            $display("FAIL shr: res=%h c=%b required 4000 1", alu_result, alu_carry);
        end
        do_write(3'd7, 16'h4002);
        set_ops(3'd7, 3'd0, 4'b1001);
        checks++;
        if (alu_result !== 16'h8004 || alu_carry !== 1'b0) begin
            errors++;
            $display("FAIL shl_nc: res=%h c=%b required 8004 0", alu_result, alu_carry);
        end
        set_ops(3'd7, 3'd0, 4'b1010);
        checks++;
        if (alu_result !== 16'h2001 || alu_carry !== 1'b0) begin
            errors++;
            $display("FAIL shr_nc: res=%h c=%b required 2001 0", alu_result, alu_carry);
        end
    endtask

    task automatic test_default_ops;
        do_write(3'd0, 16'h00C3);
        do_write(3'd1, 16'hFFFF);
        set_ops(3'd0, 3'd1, 4'b1111);
        checks++;
        if (alu_result !== 16'h00C3 || alu_carry !== 1'b0 || alu_zero !== 1'b0) begin
            errors++;
            $display("FAIL op_out: res=%h z=%b c=%b required 00c3 0 0", alu_result, alu_zero, alu_carry);
        end
        set_ops(3'd0, 3'd1, 4'b0001);
        checks++;
        if (alu_result !== 16'h00C3 || alu_carry !== 1'b0) begin
            errors++;
            $display("FAIL op_ldi: res=%h c=%b required 00c3 0", alu_result, alu_carry);
        end
        set_ops(3'd0, 3'd1, 4'b0000);
        checks++;
        if (alu_result !== 16'h00C3 || alu_carry !== 1'b0) begin
            errors++;
            $display("FAIL op_0000: res=%h c=%b required 00c3 0", alu_result, alu_carry);
        end
        set_ops(3'd2, 3'd1, 4'b1000);
        checks++;
        if (alu_result !== 16'h0001 || alu_zero !== 1'b0 || alu_carry !== 1'b0) begin
            errors++;
            $display("FAIL op_jmp: res=%h z=%b c=%b required 0001 0 0", alu_result, alu_zero, alu_carry);
        end
    endtask

    initial begin
        rst          = 1'b1;
        opcode       = 4'b0000;
        address_a    = 3'd0;
        address_b    = 3'd0;
        write_enable = 1'b0;
        write_data   = 16'h0000;
        #12;
        test_reset();
        test_write_read_add();
        test_sub_zero();
        test_read_during_write();
        test_overflow_logic();
        test_shifts();
        test_default_ops();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
